instruction_fetch_sequencer: RTL

//  Two-byte instruction fetch controller between byte-wide memory and the 16-bit IR.

---
 rtl/instruction_fetch_sequencer.sv | 66 ++++++
 1 files changed

// File: rtl/instruction_fetch_sequencer.sv
// instruction_fetch_sequencer: owns the PC and fetches a 16-bit instruction as two bytes (low at PC, high at PC+1) into the IR.
// Define FETCH_ALIGN_CHECK_EN to refuse fetches from an odd PC and report them on the sticky Misaligned flag.
module instruction_fetch_sequencer #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              FetchReq,
  input  logic              Stall,
  input  logic              PCLoad,
  input  logic [ADDR_W-1:0] PCIn,
  input  logic [7:0]        MemData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRE,
  output logic [7:0]        IR_I,
  output logic              IR_Write,
  output logic              IR_LH,
  output logic              Busy,
  output logic              FetchDone,
  output logic [ADDR_W-1:0] PCOut
`ifdef FETCH_ALIGN_CHECK_EN
  , output logic            Misaligned
`endif
);
  typedef enum logic [1:0] {IDLE, FETCH_LO, FETCH_HI, DONE} state_t;
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic ready;
  always_comb begin
    ready = state_q == IDLE || state_q == DONE;
    pc_d = ready ? (PCLoad ? PCIn : pc_q) : (Stall ? pc_q : pc_q + ONE);
    state_d = ready ? (FetchReq ? FETCH_LO : IDLE)
            : Stall ? state_q
            : state_q == FETCH_LO ? FETCH_HI : DONE;
`ifdef FETCH_ALIGN_CHECK_EN
    if (ready && FetchReq && pc_d[0]) state_d = IDLE;
`endif
  end
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
    end
`ifdef FETCH_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;
  always_comb
    misaligned_d = (ready && FetchReq && pc_d[0]) ? 1'b1 : (ready && PCLoad) ? 1'b0 : misaligned_q;
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) misaligned_q <= 1'b0;
    else misaligned_q <= misaligned_d;
  assign Misaligned = misaligned_q;
`endif
  assign MemAddr = pc_q;
  assign PCOut = pc_q;
  assign IR_I = MemData;
  assign MemRE = !ready;
  assign Busy = !ready;
  assign IR_Write = !ready && !Stall;
  assign IR_LH = state_q == FETCH_HI;
  assign FetchDone = state_q == DONE;
endmodule
